mux_n_to_1_reg: RTL and testbench

//   Parametrised N:1 datapath multiplexer with a registered output stage and

---
 rtl/mux_n_to_1_reg.sv | 97 +++++++++
 tb/tb_mux_n_to_1_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n_to_1_reg.sv
// N:1 valid/ready multiplexer with a single registered output stage.
// Channel choice is either the explicit sel index or round-robin from ptr.
module mux_n_to_1_reg #(
    parameter  int DATAWIDTH = 8,
    parameter  int NUM_IN    = 4,
    localparam int SELWIDTH  = $clog2(NUM_IN)
) (
    input  logic                        Clk,
    input  logic                        Rst_n,
    input  logic [NUM_IN*DATAWIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]           in_valid,
    output logic [NUM_IN-1:0]           in_ready,
    input  logic                        mode,
    input  logic [SELWIDTH-1:0]         sel,
    output logic [DATAWIDTH-1:0]        d,
    output logic                        d_valid,
    input  logic                        d_ready,
    output logic [SELWIDTH-1:0]         d_chan
);

    // Pad to a power of two so an out-of-range sel reads a zero valid bit.
    localparam int NUM_PAD = 1 << SELWIDTH;

    logic [NUM_PAD*DATAWIDTH-1:0] w_data_pad;
    logic [NUM_PAD-1:0]           w_valid_pad;
    logic                         w_load;
    logic [SELWIDTH-1:0]          w_rr_idx;
    logic                         w_rr_found;
    logic [SELWIDTH-1:0]          w_grant;
    logic                         w_grant_valid;

    logic [DATAWIDTH-1:0]         r_d;
    logic                         r_d_valid;
    logic [SELWIDTH-1:0]          r_d_chan;
    logic [SELWIDTH-1:0]          r_ptr;

    assign w_data_pad  = (NUM_PAD*DATAWIDTH)'(in_data);
    assign w_valid_pad = NUM_PAD'(in_valid);
    assign w_load      = ~r_d_valid | d_ready;

    always_comb begin
        int v_idx;
        v_idx      = 0;
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= NUM_IN) v_idx = v_idx - NUM_IN;
            if (!w_rr_found && w_valid_pad[SELWIDTH'(v_idx)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = SELWIDTH'(v_idx);
            end
        end
    end

    always_comb begin
        if (mode) begin
            w_grant       = w_rr_idx;
            w_grant_valid = w_rr_found;
        end else begin
            w_grant       = sel;
            w_grant_valid = w_valid_pad[sel];
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = Rst_n & w_load & w_grant_valid & (w_grant == SELWIDTH'(i));
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_d       <= '0;
            r_d_valid <= 1'b0;
            r_d_chan  <= '0;
            r_ptr     <= '0;
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_d       <= w_data_pad[w_grant*DATAWIDTH +: DATAWIDTH];
                r_d_chan  <= w_grant;
                r_d_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= (w_grant == SELWIDTH'(NUM_IN-1)) ? '0 : w_grant + 1'b1;
                end
            end else begin
                r_d_valid <= 1'b0;
            end
        end
    end

    assign d       = r_d;
    assign d_valid = r_d_valid;
    assign d_chan  = r_d_chan;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// Directed bench for mux_n_to_1_reg: a 4-input instance plus a 3-input
// instance for the out-of-range select case.
module tb_mux_n_to_1_reg;

    logic        Clk = 1'b0;
    logic        Rst_n;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  d;
    logic        d_valid;
    logic        d_ready;
    logic [1:0]  d_chan;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  d3;
    logic        d_valid3;
    logic        d_ready3;
    logic [1:0]  d_chan3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    mux_n_to_1_reg #(.DATAWIDTH(8), .NUM_IN(4)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .d(d), .d_valid(d_valid), .d_ready(d_ready), .d_chan(d_chan)
    );

    mux_n_to_1_reg #(.DATAWIDTH(8), .NUM_IN(3)) u_dut3 (
        .Clk(Clk), .Rst_n(Rst_n),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .mode(mode3), .sel(sel3),
        .d(d3), .d_valid(d_valid3), .d_ready(d_ready3), .d_chan(d_chan3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #12;
        Rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] exp_seq4 [6];
        logic [1:0] exp_seq5 [4];
        logic [7:0] ch_data  [4];
        exp_seq4 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_seq5 = '{2'd1, 2'd3, 2'd1, 2'd3};
        ch_data  = '{8'h11, 8'h22, 8'hA5, 8'h44};

        Rst_n     = 1'b0;
        in_data   = '0; in_valid  = '0; mode  = 1'b0; sel  = '0; d_ready  = 1'b0;
        in_data3  = {8'hC3, 8'hB2, 8'hA1};
        in_valid3 = '0; mode3 = 1'b0; sel3 = '0; d_ready3 = 1'b1;
        #3;
        check("rst_d",        32'(d),        32'h0);
        check("rst_d_valid",  32'(d_valid),  32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #14;
        Rst_n = 1'b1;
        tick();

        // Test 1: reset asserted while a 3C item is held
        in_data  = {8'h00, 8'h00, 8'h00, 8'h3C};
        in_valid = 4'b0001;
        mode = 1'b0; sel = 2'd0; d_ready = 1'b0;
        tick();
        check("t1_load_d",    32'(d),       32'h3C);
        check("t1_load_dv",   32'(d_valid), 32'h1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("t1_rst_d",        32'(d),        32'h0);
        check("t1_rst_d_valid",  32'(d_valid),  32'h0);
        check("t1_rst_d_chan",   32'(d_chan),   32'h0);
        check("t1_rst_in_ready", 32'(in_ready), 32'h0);
        #5;
        Rst_n = 1'b1;
        in_valid = '0;
        tick();

        // Test 2: explicit select of channel 2
        in_data  = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
        in_valid = 4'b1111;
        mode = 1'b0; sel = 2'd2; d_ready = 1'b1;
        #1;
        check("t2_in_ready", 32'(in_ready), 32'b0100);
        tick();
        check("t2_d",       32'(d),       32'hA5);
        check("t2_d_chan",  32'(d_chan),  32'd2);
        check("t2_d_valid", 32'(d_valid), 32'h1);

        // Test 3: stall for three cycles while sel and mode wander
        d_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            sel  = 2'(c);
            mode = c[0];
            #1;
            check("t3_stall_in_ready", 32'(in_ready), 32'h0);
            tick();
            check("t3_stall_d",      32'(d),       32'hA5);
            check("t3_stall_d_chan", 32'(d_chan),  32'd2);
            check("t3_stall_dv",     32'(d_valid), 32'h1);
        end
        mode = 1'b0; sel = 2'd1; d_ready = 1'b1;
        #1;
        check("t3_release_in_ready", 32'(in_ready), 32'b0010);
        tick();
        check("t3_release_d",      32'(d),      32'h22);
        check("t3_release_d_chan", 32'(d_chan), 32'd1);

        // Test 4: round-robin over all channels from reset
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; d_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t4_rr_chan",  32'(d_chan),  32'(exp_seq4[k]));
            check("t4_rr_data",  32'(d),       32'(ch_data[exp_seq4[k]]));
            check("t4_rr_valid", 32'(d_valid), 32'h1);
        end

        // Test 5: round-robin with sparse valids, then idle
        do_reset();
        mode = 1'b1; in_valid = 4'b1010; d_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t5_rr_chan", 32'(d_chan), 32'(exp_seq5[k]));
        end
        in_valid = 4'b0000;
        #1;
        check("t5_idle_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("t5_idle_dv",   32'(d_valid), 32'h0);
        check("t5_idle_d",    32'(d),       32'h44);
        check("t5_idle_chan", 32'(d_chan),  32'd3);
        tick();
        in_valid = 4'b1111;
        tick();
        check("t5_ptr_kept", 32'(d_chan), 32'd0);

        // Test 6: NUM_IN = 3, out-of-range and not-valid selects
        sel3 = 2'd3; in_valid3 = 3'b111; mode3 = 1'b0; d_ready3 = 1'b1;
        #1;
        check("t6_oor_in_ready", 32'(in_ready3), 32'h0);
        tick();
        check("t6_oor_dv", 32'(d_valid3), 32'h0);
        sel3 = 2'd1; in_valid3 = 3'b101;
        #1;
        check("t6_nv_in_ready", 32'(in_ready3), 32'h0);
        tick();
        check("t6_nv_dv", 32'(d_valid3), 32'h0);
        sel3 = 2'd2;
        #1;
        check("t6_ok_in_ready", 32'(in_ready3), 32'b100);
        tick();
        check("t6_ok_d",    32'(d3),      32'hC3);
        check("t6_ok_chan", 32'(d_chan3), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
